// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that lets NREQ requesters set/clear flags in a shared SR latch bank,
// driving exactly one latch at a time and reporting a readback mismatch or bad index via err.
module sr_flag_arbiter #(
  parameter int NREQ       = 4,
  parameter int NFLAG      = 8,
  parameter int IDXW       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic                   err,
  output logic                   busy,
  output logic [NFLAG-1:0]       lat_S,
  output logic [NFLAG-1:0]       lat_R,
  output logic [NFLAG-1:0]       lat_en,
  input  logic [NFLAG-1:0]       lat_q
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr, cap_w, win;
  logic             cap_op, win_vld, win_bad, cap_q;
  logic [IDXW-1:0]  cap_idx, win_idx;
  logic [CW-1:0]    cnt;
  logic [NFLAG-1:0] win_dec;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] w);
    return (int'(w) == NREQ - 1) ? '0 : w + PW'(1);
  endfunction

  // Scan from the far end back toward rr_ptr so the closest requester wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[(int'(rr_ptr) + j) % NREQ]) begin
        win     = PW'((int'(rr_ptr) + j) % NREQ);
        win_vld = 1'b1;
      end
    end
  end

  assign win_idx = idx[int'(win)*IDXW +: IDXW];
  assign win_bad = {1'b0, win_idx} >= (IDXW+1)'(NFLAG);

  always_comb begin
    win_dec = '0;
    cap_q   = 1'b0;
    for (int f = 0; f < NFLAG; f++) begin
      win_dec[f] = (win_idx == IDXW'(f));
      if (cap_idx == IDXW'(f)) cap_q = lat_q[f];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      lat_S   <= '0;
      lat_R   <= '0;
      lat_en  <= '0;
      rr_ptr  <= '0;
      cap_w   <= '0;
      cap_op  <= 1'b0;
      cap_idx <= '0;
      cnt     <= '0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            cap_w   <= win;
            cap_op  <= op[win];
            cap_idx <= win_idx;
            cnt     <= '0;
            busy    <= 1'b1;
            if (win_bad) begin
              // Nothing to drive: complete immediately with an error.
              state  <= CHECK;
              gnt    <= NREQ'(1) << win;
              err    <= 1'b1;
              rr_ptr <= nxt(win);
            end else begin
              state  <= DRIVE;
              lat_en <= win_dec;
              lat_S  <= op[win] ? win_dec : '0;
              lat_R  <= op[win] ? '0 : win_dec;
            end
          end
        end
        DRIVE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            // Q has settled under the drive; sample it as the drive is released.
            state  <= CHECK;
            lat_en <= '0;
            lat_S  <= '0;
            lat_R  <= '0;
            gnt    <= NREQ'(1) << cap_w;
            err    <= (cap_q != cap_op);
            rr_ptr <= nxt(cap_w);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed + randomized bench for sr_flag_arbiter against a transaction-level model
// of round-robin order, flag contents and readback errors, with a behavioural latch bank.
module tb_sr_flag_arbiter;
  localparam int NREQ = 4, NFLAG = 8, IDXW = 4, SETTLE = 1;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]      req, op, gnt;
  logic [NREQ*IDXW-1:0] idx;
  logic                 err, busy;
  logic [NFLAG-1:0]     lat_S, lat_R, lat_en, lat_q;
  logic [NFLAG-1:0]     bank = '0;
  logic [NFLAG-1:0]     flip = '0;
  logic [NFLAG-1:0]     mflags = '0;
  int checks = 0, failures = 0;
  int rr = 0;
  int w;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .gnt(gnt), .err(err),
    .busy(busy), .lat_S(lat_S), .lat_R(lat_R), .lat_en(lat_en), .lat_q(lat_q)
  );

  always #5 clk = ~clk;

  // Level-sensitive SR latch bank; flip models a stuck/inverted readback path.
  always @(lat_S, lat_R, lat_en)
    for (int i = 0; i < NFLAG; i++)
      if (lat_en[i]) begin
        if (lat_S[i]) bank[i] = 1'b1;
        else if (lat_R[i]) bank[i] = 1'b0;
      end
  assign lat_q = bank ^ flip;

  always @(negedge clk) begin
    checks++;
    assert (((lat_S & lat_R) == '0) && $onehot0(lat_en))
    else begin
      failures++;
      $error("FAIL latch_drive S=%0h R=%0h en=%0h", lat_S, lat_R, lat_en);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic o, input int i);
    req[k] = 1'b1;
    op[k]  = o;
    idx[k*IDXW +: IDXW] = IDXW'(i);
  endtask

  function automatic int model_winner();
    for (int j = 0; j < NREQ; j++)
      if (req[(rr + j) % NREQ]) return (rr + j) % NREQ;
    return -1;
  endfunction

  // Called in an IDLE cycle (#1 after an edge) with req != 0; returns in the next IDLE cycle.
  task automatic serve_one(output int wo);
    int   i;
    logic o, bad, e;
    wo  = model_winner();
    i   = int'(idx[wo*IDXW +: IDXW]);
    o   = op[wo];
    bad = (i >= NFLAG);
    @(posedge clk); #1;
    if (!bad) begin
      for (int c = 0; c < SETTLE; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        chk("drive_en", 32'(lat_en), 32'(1) << i);
        chk("drive_S", 32'(lat_S), o ? 32'(1) << i : 32'(0));
        chk("drive_R", 32'(lat_R), o ? 32'(0) : 32'(1) << i);
        chk("drive_gnt", 32'(gnt), 0);
        chk("drive_busy", 32'(busy), 1);
      end
      @(posedge clk); #1;
      mflags[i] = o;
    end
    e = bad ? 1'b1 : flip[i];
    chk("check_gnt", 32'(gnt), 32'(1) << wo);
    chk("check_err", 32'(err), 32'(e));
    chk("check_en", 32'(lat_en), 0);
    chk("check_busy", 32'(busy), 1);
    chk("bank_q", 32'(lat_q), 32'(mflags ^ flip));
    req[wo] = 1'b0;
    rr = (wo + 1) % NREQ;
    @(posedge clk); #1;
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_err", 32'(err), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_lat", 32'({lat_S, lat_R, lat_en}), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 0);

    // Continuous requests from all four, clearing distinct flags: 0,1,2,3,0
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, k);
    for (int n = 0; n < 5; n++) begin
      serve_one(w);
      chk("rr_order", 32'(w), 32'(n % NREQ));
      set_req(w, 1'b0, w);
    end
    req = '0;
    @(posedge clk); #1;

    // Single set of flag 5
    set_req(0, 1'b1, 5);
    serve_one(w);
    chk("set5_q", 32'(lat_q[5]), 1);

    // Reset during DRIVE aborts, request is re-served afterwards
    set_req(0, 1'b1, 6);
    @(posedge clk); #1;
    chk("abort_drive_en", 32'(lat_en), 32'h40);
    mflags[6] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_lat", 32'({lat_S, lat_R, lat_en}), 0);
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_busy", 32'(busy), 0);
    rst = 1'b0; rr = 0;
    serve_one(w);

    // Same flag, opposite ops: set first, clear last
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rr = 0;
    set_req(0, 1'b1, 3);
    set_req(1, 1'b0, 3);
    serve_one(w);
    chk("race_first", 32'(w), 0);
    chk("race_mid_q3", 32'(lat_q[3]), 1);
    serve_one(w);
    chk("race_last_q3", 32'(lat_q[3]), 0);

    // Out-of-range index and forced readback mismatch
    set_req(0, 1'b1, 9);
    serve_one(w);
    flip[2] = 1'b1;
    set_req(0, 1'b1, 2);
    serve_one(w);
    flip = '0;

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < NREQ; k++)
        if (!req[k] && $urandom_range(0, 2) == 0)
          set_req(k, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 8 + int'($urandom_range(0, 7))
                                              : int'($urandom_range(0, NFLAG-1)));
      if (req != '0) serve_one(w);
      else begin
        @(posedge clk); #1;
        chk("rand_idle_busy", 32'(busy), 0);
        chk("rand_idle_gnt", 32'(gnt), 0);
      end
    end
    chk("final_q", 32'(lat_q), 32'(mflags));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
